multicycle_controller: RTL and testbench

Moore-style control FSM for the multicycle MIPS core. It consumes `opcode` and `func` from the datapath's instruction register and drives every datapath control strobe: memory, IR, register file, ALU source/operation, PC source and PC write enables. One state is active per clock. Each instruction runs in 3–5 cycles and then returns to FETCH.

---
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller.sv | 139 +++++++++++++
 tb/tb_multicycle_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller is the master: it samples opcode/func and drives every strobe.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic [2:0] AluOperation;
  logic [1:0] PCSrc;
  logic [1:0] AluSrcB;
  logic       AluSrcA;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       link;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       branch;

  modport master (
    input  opcode, func,
    output AluOperation, PCSrc, AluSrcB, AluSrcA, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemToReg, RegWrite, link, PCWrite, PCWriteCond, branch
  );

  modport slave (
    output opcode, func,
    input  AluOperation, PCSrc, AluSrcB, AluSrcA, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemToReg, RegWrite, link, PCWrite, PCWriteCond, branch
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core: one state per clock,
// 2-5 cycles per instruction, outputs registered alongside the state.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
    I_EXEC = 4'd8, I_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
    JAL = 4'd12, JR = 4'd13
  } state_t;

  typedef struct packed {
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic [1:0] srcB;
    logic       srcA;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       link;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                         FN_AND = 6'b100100, FN_OR = 6'b100101, FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR = 3'b001, ALU_SLT = 3'b111;

  state_t state;
  ctrl_t  ctrlQ;
  ctrl_t  ctrlOut;

  function automatic state_t nextOf(state_t s, logic [5:0] op, logic [5:0] fn);
    case (s)
      FETCH:    nextOf = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:     nextOf = MEM_ADR;
          OP_RTYPE:         nextOf = (fn == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE:   nextOf = BRANCH;
          OP_J:             nextOf = JUMP;
          OP_JAL:           nextOf = JAL;
          OP_ADDI, OP_SLTI: nextOf = I_EXEC;
          default:          nextOf = FETCH;
        endcase
      end
      MEM_ADR:  nextOf = (op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: nextOf = MEM_WB;
      R_EXEC:   nextOf = R_WB;
      I_EXEC:   nextOf = I_WB;
      default:  nextOf = FETCH;
    endcase
  endfunction

  // Strobes for the state being entered; the datapath sees them during that state.
  function automatic ctrl_t ctrlOf(state_t s, logic [5:0] op, logic [5:0] fn);
    ctrl_t c;
    c       = '0;
    c.aluOp = ALU_ADD;
    case (s)
      FETCH:     begin c.memRead = 1'b1; c.irWrite = 1'b1; c.srcB = 2'b01; c.pcWrite = 1'b1; end
      DECODE:    c.srcB = 2'b11;
      MEM_ADR:   begin c.srcA = 1'b1; c.srcB = 2'b10; end
      MEM_READ:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
      MEM_WB:    begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
      MEM_WRITE: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
      R_EXEC: begin
        c.srcA = 1'b1;
        case (fn)
          FN_SUB:  c.aluOp = ALU_SUB;
          FN_AND:  c.aluOp = ALU_AND;
          FN_OR:   c.aluOp = ALU_OR;
          FN_SLT:  c.aluOp = ALU_SLT;
          default: c.aluOp = ALU_ADD;
        endcase
      end
      R_WB:      begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      I_EXEC: begin
        c.srcA  = 1'b1;
        c.srcB  = 2'b10;
        c.aluOp = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB:      c.regWrite = 1'b1;
      BRANCH: begin
        c.srcA        = 1'b1;
        c.aluOp       = ALU_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSrc       = 2'b01;
        c.branch      = (op == OP_BEQ);
      end
      JUMP:      begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; end
      JAL:       begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; c.link = 1'b1; c.regWrite = 1'b1; end
      JR:        begin c.pcSrc = 2'b11; c.pcWrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ctrlQ <= ctrlOf(FETCH, bus.opcode, bus.func);
    end else begin
      state <= nextOf(state, bus.opcode, bus.func);
      ctrlQ <= ctrlOf(nextOf(state, bus.opcode, bus.func), bus.opcode, bus.func);
    end
  end

  // Reset blanks the strobes immediately, so an aborted instruction commits nothing more.
  assign ctrlOut = rst ? '0 : ctrlQ;

  assign bus.AluOperation = ctrlOut.aluOp;
  assign bus.PCSrc        = ctrlOut.pcSrc;
  assign bus.AluSrcB      = ctrlOut.srcB;
  assign bus.AluSrcA      = ctrlOut.srcA;
  assign bus.IorD         = ctrlOut.iorD;
  assign bus.MemRead      = ctrlOut.memRead;
  assign bus.MemWrite     = ctrlOut.memWrite;
  assign bus.IRWrite      = ctrlOut.irWrite;
  assign bus.RegDst       = ctrlOut.regDst;
  assign bus.MemToReg     = ctrlOut.memToReg;
  assign bus.RegWrite     = ctrlOut.regWrite;
  assign bus.link         = ctrlOut.link;
  assign bus.PCWrite      = ctrlOut.pcWrite;
  assign bus.PCWriteCond  = ctrlOut.pcWriteCond;
  assign bus.branch       = ctrlOut.branch;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction cycle model checked
// every cycle, plus literal pins on selected cycles.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst;
  multicycle_controller_if bus ();

  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

  // Bit layout of the observed vector: {alu[18:16], PCSrc[15:14], SrcB[13:12],
  // SrcA 11, IorD 10, MemRead 9, MemWrite 8, IRWrite 7, RegDst 6, MemToReg 5,
  // RegWrite 4, link 3, PCWrite 2, PCWriteCond 1, branch 0}
  logic [18:0] act;
  assign act = {bus.AluOperation, bus.PCSrc, bus.AluSrcB, bus.AluSrcA, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemToReg,
                bus.RegWrite, bus.link, bus.PCWrite, bus.PCWriteCond, bus.branch};

  function automatic logic [18:0] mk(logic [2:0] a, logic [1:0] ps, logic [1:0] sb,
      logic sa, logic io, logic mr, logic mw, logic irw, logic rd, logic m2r,
      logic rw, logic lk, logic pw, logic pwc, logic br);
    return {a, ps, sb, sa, io, mr, mw, irw, rd, m2r, rw, lk, pw, pwc, br};
  endfunction

  function automatic logic [2:0] rAlu(logic [5:0] fn);
    case (fn)
      6'b100000: return ADD;
      6'b100010: return SUB;
      6'b100100: return AND_;
      6'b100101: return OR_;
      6'b101010: return SLT;
      default:   return ADD;
    endcase
  endfunction

  function automatic int lenOf(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b001000, 6'b001010: return 4;
      6'b000000: return (fn == 6'b001000) ? 3 : 4;
      6'b000100, 6'b000101, 6'b000010, 6'b000011: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction, organised per instruction.
  function automatic logic [18:0] expAt(logic [5:0] op, logic [5:0] fn, int k);
    logic [18:0] addrV;
    addrV = mk(ADD, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (k == 0) return mk(ADD, 2'd0, 2'd1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    if (k == 1) return mk(ADD, 2'd0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (op)
      6'b100011: begin
        if (k == 2) return addrV;
        if (k == 3) return mk(ADD, 2'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return mk(ADD, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      end
      6'b101011: begin
        if (k == 2) return addrV;
        return mk(ADD, 2'd0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      6'b000000: begin
        if (fn == 6'b001000) return mk(ADD, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (k == 2) return mk(rAlu(fn), 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return mk(ADD, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      end
      6'b001000, 6'b001010: begin
        if (k == 2) return mk((op == 6'b001010) ? SLT : ADD, 2'd0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return mk(ADD, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      end
      6'b000100, 6'b000101:
        return mk(SUB, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, op == 6'b000100);
      6'b000010: return mk(ADD, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      6'b000011: return mk(ADD, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      default:   return '0;
    endcase
  endfunction

  // Shared between driver (writer) and checker (reader).
  logic [18:0] expVec = '0;
  logic        expOn  = 1'b0;
  int          cyc    = 0;
  string       tag    = "reset";
  int          pinK   = -1;
  logic [18:0] pinMask = '0;
  logic [18:0] pinVal  = '0;
  int          nVec = 0;
  int          nErr = 0;

  // The single compare process.
  always @(negedge clk) begin
    if (expOn) begin
      nVec = nVec + 1;
      if (act !== expVec) begin
        nErr = nErr + 1;
        $display("FAIL %s cyc%0d: got %h want %h", tag, cyc, act, expVec);
      end
      if (pinK == cyc) begin
        nVec = nVec + 1;
        if ((act & pinMask) !== pinVal) begin
          nErr = nErr + 1;
          $display("FAIL %s_pin cyc%0d: got %h want %h (mask %h)", tag, cyc, act & pinMask, pinVal, pinMask);
        end
      end
    end
  end

  // Entered and left at posedge+#1.
  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int pk, input logic [18:0] pm, input logic [18:0] pv);
    tag = name; pinK = pk; pinMask = pm; pinVal = pv;
    bus.opcode = op; bus.func = fn;
    for (int k = 0; k < lenOf(op, fn); k++) begin
      cyc = k; expVec = expAt(op, fn, k); expOn = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; bus.opcode = 6'b100011; bus.func = 6'b000000;
    tag = "reset"; expVec = '0; expOn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc = k; @(posedge clk); #1;
    end
    rst = 1'b0;

    // First post-reset FETCH pinned to literal strobes.
    runInstr("j_after_reset", 6'b000010, 6'b0, 0, 19'h73284, 19'h21284);
    runInstr("lw",   6'b100011, 6'b0, 4, 19'h00430, 19'h00030);
    runInstr("sw",   6'b101011, 6'b0, 3, 19'h00710, 19'h00500);
    runInstr("sub",  6'b000000, 6'b100010, 2, 19'h70000, 19'h60000);
    runInstr("slt",  6'b000000, 6'b101010, 2, 19'h70000, 19'h70000);
    runInstr("and",  6'b000000, 6'b100100, 2, 19'h70000, 19'h00000);
    runInstr("or",   6'b000000, 6'b100101, 2, 19'h70000, 19'h10000);
    runInstr("rfnx", 6'b000000, 6'b111111, 3, 19'h70050, 19'h20050);
    runInstr("addi", 6'b001000, 6'b0, 2, 19'h73800, 19'h22800);
    runInstr("slti", 6'b001010, 6'b0, 2, 19'h70000, 19'h70000);
    runInstr("beq",  6'b000100, 6'b0, 2, 19'h7C007, 19'h64003);
    runInstr("bne",  6'b000101, 6'b0, 2, 19'h7C007, 19'h64002);
    runInstr("jal",  6'b000011, 6'b0, 2, 19'h0C01C, 19'h0801C);
    runInstr("jr",   6'b000000, 6'b001000, 2, 19'h0C014, 19'h0C004);
    runInstr("ill",  6'b111111, 6'b0, 1, 19'h00112, 19'h00000);

    // lw aborted by reset raised mid MEM_READ.
    tag = "lw_abort"; pinK = 4; pinMask = 19'h7FFFF; pinVal = 19'h00000;
    bus.opcode = 6'b100011; bus.func = 6'b0;
    for (int k = 0; k < 4; k++) begin
      cyc = k; expVec = expAt(6'b100011, 6'b0, k);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    cyc = 4; expVec = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    runInstr("lw_after_abort", 6'b100011, 6'b0, 0, 19'h00690, 19'h00280);
    runInstr("beq2", 6'b000100, 6'b0, -1, '0, '0);

    expOn = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
